// File: rtl/tm_vote_pkg.sv
// tm_vote_pkg: FSM states and width helpers for the class vote block.
package tm_vote_pkg;
  typedef enum logic [1:0] {IDLE, SUM, DONE} state_e;
  function automatic int sum_w(int clauses);
    return $clog2(clauses / 2 + 1) + 1;
  endfunction
  function automatic int cls_w(int classes);
    return classes > 1 ? $clog2(classes) : 1;
  endfunction
endpackage

// File: rtl/clause_polarity_sum.sv
// clause_polarity_sum: signed vote of one class, even clauses +1, odd clauses -1.
module clause_polarity_sum
  import tm_vote_pkg::*;
#(
  parameter int CLAUSE_NUM = 100,
  localparam int SUM_W = sum_w(CLAUSE_NUM)
) (
  input  logic [CLAUSE_NUM-1:0]   clause,
  output logic signed [SUM_W-1:0] sum
);
  localparam logic signed [SUM_W-1:0] ONE = SUM_W'(1);
  always_comb begin
    sum = '0;
    for (int j = 0; j < CLAUSE_NUM; j++)
      sum = !clause[j] ? sum : j[0] ? sum - ONE : sum + ONE;
  end
endmodule

// File: rtl/tm_class_vote.sv
// tm_class_vote: captures final clause vectors, sequential argmax of class votes; TM_VOTE_SUMS_EN exposes per-class sums.
module tm_class_vote
  import tm_vote_pkg::*;
#(
  parameter int CLASS_NUM = 10,
  parameter int CLAUSE_NUM = 100,
  localparam int CLS_W = cls_w(CLASS_NUM),
  localparam int SUM_W = sum_w(CLAUSE_NUM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CLAUSE_NUM-1:0]   partial_clause [CLASS_NUM],
  input  logic                    clause_valid,
  output logic                    in_ready,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [CLS_W-1:0]        result_class,
  output logic signed [SUM_W-1:0] result_sum
`ifdef TM_VOTE_SUMS_EN
  ,
  output logic signed [SUM_W-1:0] class_sum [CLASS_NUM]
`endif
);
  localparam logic signed [SUM_W-1:0] MIN_SUM = {1'b1, {(SUM_W-1){1'b0}}};
  state_e state_q, state_d;
  logic [CLS_W-1:0] idx_q, idx_d, best_cls_q, best_cls_d, res_cls_q, res_cls_d;
  logic signed [SUM_W-1:0] best_sum_q, best_sum_d, res_sum_q, res_sum_d, sum;
  logic rv_q, rv_d, better, last;
  logic [CLAUSE_NUM-1:0] cap_q [CLASS_NUM];
  logic [CLAUSE_NUM-1:0] cap_d [CLASS_NUM];
`ifdef TM_VOTE_SUMS_EN
  logic signed [SUM_W-1:0] cs_q [CLASS_NUM];
  logic signed [SUM_W-1:0] cs_d [CLASS_NUM];
  assign class_sum = cs_q;
`endif
  clause_polarity_sum #(.CLAUSE_NUM(CLAUSE_NUM)) u_sum (.clause(cap_q[idx_q]), .sum(sum));
  assign better = sum > best_sum_q;
  assign last = idx_q == CLS_W'(CLASS_NUM - 1);
  assign in_ready = state_q == IDLE;
  assign result_valid = rv_q;
  assign result_class = res_cls_q;
  assign result_sum = res_sum_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    best_cls_d = best_cls_q;
    best_sum_d = best_sum_q;
    res_cls_d = res_cls_q;
    res_sum_d = res_sum_q;
    rv_d = rv_q;
    cap_d = cap_q;
`ifdef TM_VOTE_SUMS_EN
    cs_d = cs_q;
`endif
    case (state_q)
      IDLE: if (clause_valid) begin
        cap_d = partial_clause;
        idx_d = '0;
        best_sum_d = MIN_SUM;
        best_cls_d = '0;
        state_d = SUM;
      end
      SUM: begin
        best_sum_d = better ? sum : best_sum_q;
        best_cls_d = better ? idx_q : best_cls_q;
        idx_d = idx_q + 1'b1;
`ifdef TM_VOTE_SUMS_EN
        cs_d[idx_q] = sum;
`endif
        if (last) begin
          res_sum_d = best_sum_d;
          res_cls_d = best_cls_d;
          rv_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (result_ready) begin
        rv_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      best_cls_q <= '0;
      best_sum_q <= '0;
      res_cls_q <= '0;
      res_sum_q <= '0;
      rv_q <= 1'b0;
      cap_q <= '{default: '0};
`ifdef TM_VOTE_SUMS_EN
      cs_q <= '{default: '0};
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      best_cls_q <= best_cls_d;
      best_sum_q <= best_sum_d;
      res_cls_q <= res_cls_d;
      res_sum_q <= res_sum_d;
      rv_q <= rv_d;
      cap_q <= cap_d;
`ifdef TM_VOTE_SUMS_EN
      cs_q <= cs_d;
`endif
    end
  end
endmodule

// File: tb/tb_tm_class_vote.sv
// tb_tm_class_vote: randomized and directed checks of tm_class_vote against a vote-counting model.
module tb_tm_class_vote;
  localparam int CLASS_NUM = 10;
  localparam int CLAUSE_NUM = 100;
  localparam int CLS_W = $clog2(CLASS_NUM);
  localparam int SUM_W = $clog2(CLAUSE_NUM / 2 + 1) + 1;
  typedef logic [CLAUSE_NUM-1:0] vec_t [CLASS_NUM];
  typedef int sums_t [CLASS_NUM];

  logic clk = 1'b0, rst = 1'b1, clause_valid = 1'b0, result_ready = 1'b0;
  vec_t partial_clause = '{default: '0};
  logic in_ready, result_valid;
  logic [CLS_W-1:0] result_class;
  logic signed [SUM_W-1:0] result_sum;
`ifdef TM_VOTE_SUMS_EN
  logic signed [SUM_W-1:0] class_sum [CLASS_NUM];
`endif
  int tests = 0, fails = 0;

  tm_class_vote #(.CLASS_NUM(CLASS_NUM), .CLAUSE_NUM(CLAUSE_NUM)) dut (
    .clk(clk), .rst(rst), .partial_clause(partial_clause), .clause_valid(clause_valid),
    .in_ready(in_ready), .result_valid(result_valid), .result_ready(result_ready),
    .result_class(result_class), .result_sum(result_sum)
`ifdef TM_VOTE_SUMS_EN
    , .class_sum(class_sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Vote per class: count of set even clauses minus count of set odd clauses; first maximum wins.
  task automatic model(input vec_t v, output int cls, output int sm, output sums_t s);
    cls = 0;
    sm = -1000;
    for (int c = 0; c < CLASS_NUM; c++) begin
      s[c] = 0;
      for (int j = 0; j < CLAUSE_NUM; j++)
        if (v[c][j]) s[c] += (j % 2 == 0) ? 1 : -1;
      if (s[c] > sm) begin
        sm = s[c];
        cls = c;
      end
    end
  endtask

  task automatic send(input vec_t v, output int lat);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    partial_clause = v;
    clause_valid = 1'b1;
    tick;
    clause_valid = 1'b0;
    lat = 0;
    while (!result_valid && lat < 100) begin
      tick;
      lat++;
    end
  endtask

  task automatic ack;
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++;
    if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", result_valid); end
    tests++;
    if (result_class !== '0) begin fails++; $display("FAIL reset_class got %0d exp 0", result_class); end
    tests++;
    if (result_sum !== '0) begin fails++; $display("FAIL reset_sum got %0d exp 0", result_sum); end
  endtask

  task automatic test_zero;
    vec_t v = '{default: '0};
    int lat;
    send(v, lat);
    tests++;
    if (lat !== CLASS_NUM) begin fails++; $display("FAIL zero_latency got %0d exp %0d", lat, CLASS_NUM); end
    tests++;
    if (result_class !== 0 || int'(result_sum) !== 0) begin
      fails++; $display("FAIL zero_result got %0d/%0d exp 0/0", result_class, result_sum);
    end
    ack;
    tests++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0) begin
      fails++; $display("FAIL zero_handshake got ready %b valid %b exp 1/0", in_ready, result_valid);
    end
  endtask

  task automatic test_class3;
    vec_t v = '{default: '0};
    int lat;
    for (int j = 0; j < 8; j += 2) v[3][j] = 1'b1;
    send(v, lat);
    tests++;
    if (result_class !== 3 || int'(result_sum) !== 4) begin
      fails++; $display("FAIL class3 got %0d/%0d exp 3/4", result_class, result_sum);
    end
    ack;
  endtask

  task automatic test_tie;
    vec_t v;
    int lat;
    for (int c = 0; c < CLASS_NUM; c++) begin
      v[c] = '0;
      if (c == 2 || c == 7) for (int j = 0; j < 10; j += 2) v[c][j] = 1'b1;
      else v[c][1] = 1'b1;
    end
    send(v, lat);
    tests++;
    if (result_class !== 2 || int'(result_sum) !== 5) begin
      fails++; $display("FAIL tie got %0d/%0d exp 2/5", result_class, result_sum);
    end
    ack;
  endtask

  task automatic test_min;
    vec_t v;
    int lat;
    for (int c = 0; c < CLASS_NUM; c++)
      for (int j = 0; j < CLAUSE_NUM; j++) v[c][j] = j % 2 == 1;
    send(v, lat);
    tests++;
    if (result_class !== 0 || int'(result_sum) !== -CLAUSE_NUM / 2) begin
      fails++; $display("FAIL min got %0d/%0d exp 0/%0d", result_class, result_sum, -CLAUSE_NUM / 2);
    end
    ack;
  endtask

  task automatic test_stall;
    vec_t v1 = '{default: '0};
    vec_t v2 = '{default: '0};
    int c1, s1, c2, s2, n;
    sums_t a;
    bit bad = 0;
    for (int j = 0; j < 10; j += 2) v1[5][j] = 1'b1;
    for (int j = 0; j < 20; j += 2) v2[8][j] = 1'b1;
    model(v1, c1, s1, a);
    model(v2, c2, s2, a);
    partial_clause = v1;
    clause_valid = 1'b1;
    tick;
    clause_valid = 1'b0;
    tick;
    tick;
    partial_clause = v2;
    clause_valid = 1'b1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_sum_in_ready got %b exp 0", in_ready); end
    tick;
    clause_valid = 1'b0;
    n = 0;
    while (!result_valid && n < 100) begin
      tick;
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      clause_valid = i == 5;
      if (result_valid !== 1'b1 || in_ready !== 1'b0 || int'(result_class) !== c1 || int'(result_sum) !== s1)
        bad = 1;
      tick;
    end
    clause_valid = 1'b0;
    tests++;
    if (bad) begin fails++; $display("FAIL stall_hold got %0d/%0d valid %b exp %0d/%0d valid 1", result_class, result_sum, result_valid, c1, s1); end
    ack;
    tests++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0) begin
      fails++; $display("FAIL stall_release got ready %b valid %b exp 1/0", in_ready, result_valid);
    end
    tests++;
    if (int'(result_class) !== c1 || int'(result_sum) !== s1) begin
      fails++; $display("FAIL stall_keep got %0d/%0d exp %0d/%0d", result_class, result_sum, c1, s1);
    end
    bad = 0;
    for (int i = 0; i < CLASS_NUM + 2; i++) begin
      if (result_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
      tick;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL stall_ignored got valid %b ready %b exp 0/1", result_valid, in_ready); end
  endtask

  task automatic test_rst_mid;
    vec_t v1 = '{default: '0};
    vec_t v2 = '{default: '0};
    int c2, s2, lat;
    sums_t a;
    bit bad = 0;
    for (int j = 0; j < 30; j += 2) v1[6][j] = 1'b1;
    for (int j = 0; j < 6; j += 2) v2[1][j] = 1'b1;
    v2[4][0] = 1'b1;
    model(v2, c2, s2, a);
    partial_clause = v1;
    clause_valid = 1'b1;
    tick;
    clause_valid = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0) begin
      fails++; $display("FAIL rst_mid got ready %b valid %b exp 1/0", in_ready, result_valid);
    end
    rst = 1'b1;
    clause_valid = 1'b1;
    tick;
    rst = 1'b0;
    clause_valid = 1'b0;
    for (int i = 0; i < CLASS_NUM + 2; i++) begin
      if (result_valid !== 1'b0 || in_ready !== 1'b1) bad = 1;
      tick;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL rst_capture got valid %b ready %b exp 0/1", result_valid, in_ready); end
    send(v2, lat);
    tests++;
    if (lat !== CLASS_NUM || int'(result_class) !== c2 || int'(result_sum) !== s2) begin
      fails++; $display("FAIL rst_new got %0d/%0d lat %0d exp %0d/%0d lat %0d", result_class, result_sum, lat, c2, s2, CLASS_NUM);
    end
    ack;
  endtask

  task automatic test_random;
    vec_t v;
    int ec, es, lat;
    sums_t s;
    for (int it = 0; it < 12; it++) begin
      for (int c = 0; c < CLASS_NUM; c++) begin
        int d = $urandom_range(1, 7);
        for (int j = 0; j < CLAUSE_NUM; j++) v[c][j] = $urandom_range(0, 7) < d;
      end
      if (it % 3 == 0) v[$urandom_range(5, 9)] = v[$urandom_range(0, 4)];
      model(v, ec, es, s);
      send(v, lat);
      tests++;
      if (lat !== CLASS_NUM || int'(result_class) !== ec || int'(result_sum) !== es) begin
        fails++; $display("FAIL random_%0d got %0d/%0d lat %0d exp %0d/%0d lat %0d", it, result_class, result_sum, lat, ec, es, CLASS_NUM);
      end
`ifdef TM_VOTE_SUMS_EN
      for (int c = 0; c < CLASS_NUM; c++) begin
        tests++;
        if (int'(class_sum[c]) !== s[c]) begin
          fails++; $display("FAIL class_sum_%0d_%0d got %0d exp %0d", it, c, class_sum[c], s[c]);
        end
      end
`endif
      repeat ($urandom_range(0, 3)) tick;
      ack;
    end
  endtask

  task automatic test_back_to_back;
    vec_t v1, v2;
    int c1, s1, c2, s2, lat;
    sums_t a;
    for (int c = 0; c < CLASS_NUM; c++) begin
      v1[c] = {$urandom, $urandom, $urandom, $urandom};
      v2[c] = {$urandom, $urandom, $urandom, $urandom};
    end
    model(v1, c1, s1, a);
    model(v2, c2, s2, a);
    result_ready = 1'b1;
    send(v1, lat);
    tests++;
    if (lat !== CLASS_NUM || int'(result_class) !== c1 || int'(result_sum) !== s1) begin
      fails++; $display("FAIL b2b_first got %0d/%0d lat %0d exp %0d/%0d", result_class, result_sum, lat, c1, s1);
    end
    tick;
    tests++;
    if (in_ready !== 1'b1 || result_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_done_one got ready %b valid %b exp 1/0", in_ready, result_valid);
    end
    send(v2, lat);
    tests++;
    if (lat !== CLASS_NUM || int'(result_class) !== c2 || int'(result_sum) !== s2) begin
      fails++; $display("FAIL b2b_second got %0d/%0d lat %0d exp %0d/%0d", result_class, result_sum, lat, c2, s2);
    end
    tick;
    result_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_zero;
    test_class3;
    test_tie;
    test_min;
    test_stall;
    test_rst_mid;
    test_random;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
